multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, maximum cycles spent in one memory wait state before abort (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 Funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 Zero  input  1  ALU zero flag, combinational from the ALU in the current cycle.
REQ-007 MemReady  input  1  memory handshake, 1 = access completes this cycle.
REQ-008 AluOp  output  4  ALU operation code: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, SLL 1101, SRL 1110, SRA 1000.
REQ-009 MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, ALUSrcA  output  1 each  datapath strobes and selects.
REQ-010 ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-011 PCSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 State  output  4  current state encoding; Illegal, MemErr  output  1 each  single-cycle error pulses.

Function
REQ-013 States: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; encodings 12-15 go to FETCH on the next edge.
REQ-014 Outputs are decoded from State (Moore); only PCWrite in BRANCH and the handshake strobes in wait states also depend on Zero/MemReady.
REQ-015 Unlisted outputs are 0 in every state; AluOp defaults to ADD.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00; IRWrite=PCWrite=MemReady; on MemReady -> DECODE, else stay.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ADD; next: lw 100011 / sw 101011 -> MEMADR, R-type 000000 -> EXECUTE, beq 000100 / bne 000101 -> BRANCH, addi 001000 -> ADDIEX, j 000010 -> JUMP; any other opcode -> FETCH with Illegal=1 for that cycle.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; lw -> MEMREAD, sw -> MEMWRITE.
REQ-019 MEMREAD: MemRead=1, IorD=1; on MemReady -> MEMWB. MEMWB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
REQ-020 MEMWRITE: MemWrite=1, IorD=1; on MemReady -> FETCH.
REQ-021 EXECUTE: ALUSrcA=1, ALUSrcB=00; AluOp by Funct: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL, 000011 SRA -> ALUWB.
REQ-022 EXECUTE with unlisted Funct: AluOp=ADD, Illegal=1, next FETCH (no ALUWB, no register write).
REQ-023 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01; PCWrite=Zero for beq, ~Zero for bne -> FETCH.
REQ-025 ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
REQ-026 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-027 Wait counter (8 bits) clears on entry to FETCH, MEMREAD or MEMWRITE and increments each cycle in them without MemReady.
REQ-028 When the counter equals MEM_TIMEOUT and MemReady=0: MemErr=1 for that cycle, no strobe commits (IRWrite, PCWrite and MemWrite are gated with MemReady), next FETCH with counter cleared.
REQ-029 MemReady in the same cycle as the timeout takes priority: normal completion, no MemErr.
REQ-030 MemReady outside wait states is ignored.
REQ-031 Opcode and Funct are sampled only in DECODE and EXECUTE respectively.

Reset
REQ-032 rst_n=0 immediately forces State=FETCH, counter=0, Illegal=MemErr=0, regardless of clk.
REQ-033 During reset all strobes are 0, AluOp=ADD, ALUSrcB=01, PCSrc=00.
REQ-034 Reset mid-instruction abandons it; first edge after rst_n rises evaluates FETCH.

Verification
REQ-035 add (Opcode 000000, Funct 100000), MemReady=1 on the first FETCH cycle -> FETCH, DECODE, EXECUTE (AluOp 0010), ALUWB (RegWrite=1, RegDst=1): 4 cycles.
REQ-036 lw with MemReady delayed 3 cycles in MEMREAD -> 3 cycles MEMREAD with RegWrite=0, then MEMWB with MemtoReg=1, RegWrite=1.
REQ-037 beq with Zero=1 -> PCWrite=1, PCSrc=01 in BRANCH; bne with Zero=1 -> PCWrite=0.
REQ-038 sw, MemReady held 0, MEM_TIMEOUT=15 -> MemErr=1 on 16th MEMWRITE cycle, MemWrite gated, next State=FETCH.
REQ-039 Opcode 111111 in DECODE -> Illegal=1 one cycle, State 1->0; Funct 111111 in EXECUTE -> Illegal=1, no RegWrite.
REQ-040 rst_n low asynchronously while in MEMREAD -> State=0 and all strobes 0 before next clk edge.

Source files
------------

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Moore-style control FSM for a multicycle MIPS-like datapath. Sequences
//   fetch / decode / execute / memory / write-back and supervises memory
//   waits with a timeout counter.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   Opcode[5:0]       instruction bits [31:26], used in DECODE only
//   Funct[5:0]        instruction bits [5:0], used in EXECUTE only
//   Zero              ALU zero flag (combinational, current cycle)
//   MemReady          memory handshake, 1 = access completes this cycle
//   AluOp[3:0]        ALU operation code
//   MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst,
//   MemtoReg, ALUSrcA datapath strobes / selects
//   ALUSrcB[1:0]      00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//   PCSrc[1:0]        00 ALU result, 01 ALUOut, 10 jump target
//   State[3:0]        current state encoding
//   Illegal, MemErr   single-cycle error pulses
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [3:0] AluOp,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [3:0] State,
  output logic       Illegal,
  output logic       MemErr
);

  // State encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1101;
  localparam logic [3:0] ALU_SRL = 4'b1110;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  // R-type funct decode table: each entry is one legal funct code and the
  // ALU operation it selects.
  localparam int NF = 11;
  localparam logic [5:0] FUNCT_TBL [NF] = '{
    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
    6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011
  };
  localparam logic [3:0] ALUOP_TBL [NF] = '{
    ALU_ADD, ALU_ADD, ALU_SUB, ALU_SUB, ALU_AND, ALU_OR,
    ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  };

  logic [3:0] state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  // Instruction flavour remembered from DECODE, since Opcode is not looked
  // at again later in the instruction.
  logic       is_sw_reg, is_sw_next;
  logic       is_bne_reg, is_bne_next;

  logic [NF-1:0] funct_hit;
  logic          funct_legal;
  logic [3:0]    funct_aluop;
  logic          in_wait;
  logic          timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NF; gi++) begin : g_funct
      assign funct_hit[gi] = (Funct == FUNCT_TBL[gi]);
    end
  endgenerate

  always_comb begin
    funct_aluop = ALU_ADD;
    for (int i = 0; i < NF; i++) begin
      if (funct_hit[i]) funct_aluop = ALUOP_TBL[i];
    end
  end

  assign funct_legal = |funct_hit;

  assign in_wait = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                   (state_reg == S_MEMWRITE);
  // MemReady in the timeout cycle wins: only a cycle without it aborts.
  assign timeout = in_wait && !MemReady && (cnt_reg == TIMEOUT_VAL);

  // Next-state logic
  always_comb begin
    state_next  = S_FETCH;
    is_sw_next  = is_sw_reg;
    is_bne_next = is_bne_reg;
    case (state_reg)
      S_FETCH:    state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        is_sw_next  = (Opcode == OP_SW);
        is_bne_next = (Opcode == OP_BNE);
        case (Opcode)
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_RTYPE:       state_next = S_EXECUTE;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI:        state_next = S_ADDIEX;
          OP_J:           state_next = S_JUMP;
          default:        state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = is_sw_reg ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = MemReady ? S_MEMWB :
                               (timeout ? S_FETCH : S_MEMREAD);
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = (MemReady || timeout) ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_next = funct_legal ? S_ALUWB : S_FETCH;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_ADDIEX:   state_next = S_ADDIWB;
      S_ADDIWB:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // The counter keeps running only while the FSM stays in the same wait
  // state; any transition (including FETCH->FETCH after a timeout) clears it.
  always_comb begin
    if (in_wait && (state_next == state_reg) && !timeout)
      cnt_next = cnt_reg + 8'd1;
    else
      cnt_next = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_FETCH;
      cnt_reg    <= 8'd0;
      is_sw_reg  <= 1'b0;
      is_bne_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      is_sw_reg  <= is_sw_next;
      is_bne_reg <= is_bne_next;
    end
  end

  // Output decode
  always_comb begin
    AluOp    = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    Illegal  = 1'b0;
    MemErr   = timeout;
    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J: Illegal = 1'b0;
          default: Illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        // The write strobe is withheld in the aborting cycle.
        MemWrite = !timeout;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        AluOp   = funct_aluop;
        Illegal = !funct_legal;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        AluOp   = ALU_SUB;
        PCSrc   = 2'b01;
        PCWrite = is_bne_reg ? !Zero : Zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase

    // Reset overrides the decode directly, so strobes drop without waiting
    // for a clock edge even though FETCH normally drives MemRead.
    if (!rst_n) begin
      AluOp    = ALU_ADD;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b01;
      PCSrc    = 2'b00;
      Illegal  = 1'b0;
      MemErr   = 1'b0;
    end
  end

  assign State = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic [3:0] AluOp;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite;
  logic       RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] State;
  logic       Illegal, MemErr;

  int pass_cnt = 0;
  int total_cnt = 0;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .AluOp(AluOp), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .State(State),
    .Illegal(Illegal), .MemErr(MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %-22s obs=%0h exp=%0h ok", name, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance one clock; inputs may be changed after this returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b1;
    #12;
    // Reset: FETCH, every strobe low even though MemReady is high
    chk("rst_state",   32'(State), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd0);
    chk("rst_pcwrite", 32'(PCWrite), 32'd0);
    chk("rst_aluop",   32'(AluOp), 32'b0010);
    chk("rst_alusrcb", 32'(ALUSrcB), 32'b01);
    chk("rst_errs",    32'({Illegal, MemErr}), 32'd0);

    // ---- add: FETCH, DECODE, EXECUTE, ALUWB ----
    rst_n = 1'b1; Opcode = 6'b000000; Funct = 6'b100000; MemReady = 1'b1;
    #1;
    chk("add_fetch_ir",  32'({MemRead, IRWrite, PCWrite}), 32'b111);
    chk("add_fetch_srcb", 32'(ALUSrcB), 32'b01);
    step(); MemReady = 1'b0; #1;
    chk("add_decode_state", 32'(State), 32'd1);
    chk("add_decode_srcb",  32'(ALUSrcB), 32'b11);
    step();
    chk("add_exec_state", 32'(State), 32'd6);
    chk("add_exec_aluop", 32'(AluOp), 32'b0010);
    chk("add_exec_src",   32'({ALUSrcA, ALUSrcB}), 32'b100);
    step();
    chk("add_wb_state", 32'(State), 32'd7);
    chk("add_wb_ctl",   32'({RegWrite, RegDst, MemtoReg}), 32'b110);
    step();
    chk("add_back_fetch", 32'(State), 32'd0);

    // ---- sra funct decode ----
    MemReady = 1'b1; Funct = 6'b000011;
    step(); step();
    chk("sra_aluop", 32'(AluOp), 32'b1000);
    step(); step();

    // ---- lw with MemReady delayed 3 cycles ----
    Opcode = 6'b100011; MemReady = 1'b1;
    step();
    chk("lw_decode", 32'(State), 32'd1);
    step(); MemReady = 1'b0; #1;
    chk("lw_memadr", 32'({State, ALUSrcA, ALUSrcB}), 32'({4'd2, 1'b1, 2'b10}));
    step();
    chk("lw_mr1", 32'({State, MemRead, IorD, RegWrite}), 32'({4'd3, 3'b110}));
    step();
    chk("lw_mr2", 32'({State, RegWrite}), 32'({4'd3, 1'b0}));
    step(); MemReady = 1'b1; #1;
    chk("lw_mr3", 32'({State, RegWrite, MemErr}), 32'({4'd3, 2'b00}));
    step();
    chk("lw_memwb", 32'({State, RegWrite, RegDst, MemtoReg}), 32'({4'd4, 3'b101}));
    step();
    chk("lw_fetch", 32'(State), 32'd0);

    // ---- beq, Zero=1 then Zero=0 ----
    Opcode = 6'b000100; Zero = 1'b1;
    step(); step();
    chk("beq_state", 32'(State), 32'd8);
    chk("beq_taken", 32'({PCWrite, PCSrc, AluOp}), 32'({1'b1, 2'b01, 4'b0110}));
    Zero = 1'b0; #1;
    chk("beq_not_taken", 32'(PCWrite), 32'd0);
    step();

    // ---- bne with Zero=1: not taken ----
    Opcode = 6'b000101; Zero = 1'b1;
    step(); step();
    chk("bne_zero", 32'({State, PCWrite}), 32'({4'd8, 1'b0}));
    step();

    // ---- jump ----
    Opcode = 6'b000010;
    step(); step();
    chk("jump", 32'({State, PCWrite, PCSrc}), 32'({4'd11, 1'b1, 2'b10}));
    step();

    // ---- addi ----
    Opcode = 6'b001000;
    step(); step();
    chk("addiex", 32'({State, ALUSrcA, ALUSrcB}), 32'({4'd9, 1'b1, 2'b10}));
    step();
    chk("addiwb", 32'({State, RegWrite, RegDst, MemtoReg}), 32'({4'd10, 3'b100}));
    step();

    // ---- sw, MemReady held low: timeout on 16th MEMWRITE cycle ----
    Opcode = 6'b101011; MemReady = 1'b1;
    step(); step(); MemReady = 1'b0; #1;
    step();
    chk("sw_mw1", 32'({State, MemWrite, IorD, MemErr}), 32'({4'd5, 3'b110}));
    repeat (14) step();
    chk("sw_mw15", 32'({State, MemWrite, MemErr}), 32'({4'd5, 2'b10}));
    step();
    chk("sw_mw16", 32'({State, MemWrite, MemErr}), 32'({4'd5, 2'b01}));
    step();
    chk("sw_after_to", 32'({State, IRWrite, MemErr}), 32'({4'd0, 2'b00}));

    // ---- lw: MemReady arriving in the timeout cycle wins ----
    Opcode = 6'b100011; MemReady = 1'b1;
    step(); step(); MemReady = 1'b0; #1;
    step();
    repeat (15) step();
    MemReady = 1'b1; #1;
    chk("lw_prio", 32'({State, MemErr}), 32'({4'd3, 1'b0}));
    step();
    chk("lw_prio_wb", 32'(State), 32'd4);
    step();

    // ---- illegal opcode ----
    Opcode = 6'b111111; MemReady = 1'b1;
    step();
    chk("ill_op_dec", 32'({State, Illegal}), 32'({4'd1, 1'b1}));
    step();
    chk("ill_op_next", 32'({State, Illegal}), 32'({4'd0, 1'b0}));

    // ---- illegal funct ----
    Opcode = 6'b000000; Funct = 6'b111111;
    step(); step();
    chk("ill_fn_exec", 32'({State, Illegal, RegWrite, AluOp}), 32'({4'd6, 2'b10, 4'b0010}));
    step();
    chk("ill_fn_next", 32'({State, RegWrite}), 32'({4'd0, 1'b0}));

    // ---- async reset in MEMREAD ----
    Opcode = 6'b100011; MemReady = 1'b1;
    step(); step(); MemReady = 1'b0; #1;
    step();
    chk("ar_in_memread", 32'(State), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(State), 32'd0);
    chk("ar_strobes", 32'({MemRead, IorD, MemWrite, IRWrite, PCWrite, RegWrite}), 32'd0);
    step();
    rst_n = 1'b1; MemReady = 1'b1; #1;
    step();
    chk("ar_resume", 32'(State), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
